// File: rtl/line_buffer_ctrl.sv
// Raster-stream sequencer for the line buffers and 3x3 window of the pattern recognizer.
// Tracks pixel position, drives line-buffer writes and qualifies complete windows.
module line_buffer_ctrl #(
  parameter int unsigned IMG_WIDTH  = 1280,
  parameter int unsigned IMG_HEIGHT = 720,
  parameter int unsigned KERNEL     = 3,
  parameter int unsigned COL_W      = 11,
  parameter int unsigned ROW_W      = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  input  logic             s_sof,
  output logic             s_ready,
  input  logic             m_ready,
  output logic             lb_write_enable,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             win_valid,
  output logic             win_eol,
  output logic             win_eof,
  output logic             frame_done,
  output logic             sof_error
);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] KCOL     = COL_W'(KERNEL - 1);
  localparam logic [ROW_W-1:0] KROW     = ROW_W'(KERNEL - 1);

  state_t           r_state, w_state_nxt;
  logic [COL_W-1:0] r_col, w_col_nxt, w_px_col;
  logic [ROW_W-1:0] r_row, w_row_nxt, w_px_row;
  logic             w_accept, w_restart, w_take;
  logic             w_last_col, w_last_row, w_qual;
  logic             r_win_valid, r_win_eol, r_win_eof, r_sof_error;

  always_comb begin
    s_ready     = m_ready && (r_state != DONE);
    w_accept    = s_valid && s_ready;
    // An accepted sof always denotes pixel (0,0), whether starting or restarting a frame
    w_restart   = w_accept && s_sof;
    w_take      = w_restart || (w_accept && (r_state == ACTIVE));
    w_px_col    = w_restart ? '0 : r_col;
    w_px_row    = w_restart ? '0 : r_row;
    w_last_col  = (w_px_col == LAST_COL);
    w_last_row  = (w_px_row == LAST_ROW);
    w_qual      = w_take && (w_px_col >= KCOL) && (w_px_row >= KROW);
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    case (r_state)
      DONE: w_state_nxt = IDLE;
      default: begin
        if (w_take) begin
          w_state_nxt = ACTIVE;
          if (w_last_col) begin
            w_col_nxt = '0;
            if (w_last_row) begin
              w_row_nxt   = '0;
              w_state_nxt = DONE;
            end else begin
              w_row_nxt = w_px_row + ROW_W'(1);
            end
          end else begin
            w_col_nxt = w_px_col + COL_W'(1);
            w_row_nxt = w_px_row;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_col       <= '0;
      r_row       <= '0;
      r_win_valid <= 1'b0;
      r_win_eol   <= 1'b0;
      r_win_eof   <= 1'b0;
      r_sof_error <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_col       <= w_col_nxt;
      r_row       <= w_row_nxt;
      r_sof_error <= w_restart && (r_state == ACTIVE);
      // Window flags hold while downstream stalls; a new window overwrites them
      if (w_qual) begin
        r_win_valid <= 1'b1;
        r_win_eol   <= w_last_col;
        r_win_eof   <= w_last_col && w_last_row;
      end else if (m_ready) begin
        r_win_valid <= 1'b0;
        r_win_eol   <= 1'b0;
        r_win_eof   <= 1'b0;
      end
    end
  end

  assign lb_write_enable = w_take;
  assign col             = r_col;
  assign row             = r_row;
  assign win_valid       = r_win_valid;
  assign win_eol         = r_win_eol;
  assign win_eof         = r_win_eof;
  assign frame_done      = (r_state == DONE);
  assign sof_error       = r_sof_error;

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Bench for line_buffer_ctrl on a small 8x5 image; reference model tracks a linear pixel index.
module tb_line_buffer_ctrl;
  localparam int W = 8, H = 5, K = 3, CW = 3, RW = 3;
  localparam int NPIX = W * H;
  localparam int NWIN = (H - K + 1) * (W - K + 1);

  logic clk = 1'b0;
  logic reset, s_valid, s_sof, s_ready, m_ready, lb_write_enable;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic win_valid, win_eol, win_eof, frame_done, sof_error;

  int n_checks = 0, n_fail = 0;
  bit m_act, m_done, m_wv, m_weol, m_weof, m_serr;
  int m_idx;
  logic [1:0]       exp_pre, obs_pre;
  logic [CW+RW+4:0] exp_post, obs_post;
  int consumed;

  line_buffer_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .KERNEL(K), .COL_W(CW), .ROW_W(RW)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_sof(s_sof), .s_ready(s_ready),
    .m_ready(m_ready), .lb_write_enable(lb_write_enable), .col(col), .row(row),
    .win_valid(win_valid), .win_eol(win_eol), .win_eof(win_eof),
    .frame_done(frame_done), .sof_error(sof_error));

  always #5 clk = ~clk;

  task automatic model_update(input bit v, input bit sof, input bit mr, input bit rst);
    bit acc, take, nserr, qual;
    int pix;
    if (rst) begin
      m_act = 0; m_done = 0; m_idx = 0;
      m_wv = 0; m_weol = 0; m_weof = 0; m_serr = 0;
      return;
    end
    acc   = v && mr && !m_done;
    take  = acc && (sof || m_act);
    nserr = acc && sof && m_act;
    qual  = 0;
    if (m_done) m_done = 0;
    else if (take) begin
      pix  = sof ? 0 : m_idx;
      qual = (pix / W >= K - 1) && (pix % W >= K - 1);
      if (qual) begin
        m_weol = (pix % W == W - 1);
        m_weof = (pix == NPIX - 1);
      end
      if (pix == NPIX - 1) begin m_act = 0; m_done = 1; m_idx = 0; end
      else begin m_act = 1; m_idx = pix + 1; end
    end
    if (qual) m_wv = 1;
    else if (mr) begin m_wv = 0; m_weol = 0; m_weof = 0; end
    m_serr = nserr;
  endtask

  task automatic step(input bit v, input bit sof, input bit mr, input bit rst);
    s_valid = v; s_sof = sof; m_ready = mr; reset = rst;
    #1;
    exp_pre = {mr && !m_done, v && mr && !m_done && (m_act || sof)};
    obs_pre = {s_ready, lb_write_enable};
    if (win_valid && m_ready) consumed++;
    @(posedge clk);
    model_update(v, sof, mr, rst);
    #1;
    exp_post = {CW'(m_idx % W), RW'(m_idx / W), m_wv, m_weol, m_weof, m_done, m_serr};
    obs_post = {col, row, win_valid, win_eol, win_eof, frame_done, sof_error};
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 1, 1);
      n_checks++;
      if (obs_post !== '0) begin
        n_fail++;
        $display("FAIL reset.outputs got %b want %b", obs_post, {(CW+RW+5){1'b0}});
      end
    end
    step(0, 0, 1, 0);
    n_checks++;
    if (obs_pre !== 2'b10) begin n_fail++; $display("FAIL reset.ready got %b want 10", obs_pre); end
  endtask

  task automatic test_idle_drop();
    step(0, 0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 1, 0);
      n_checks++;
      if (lb_write_enable !== 1'b0 || col !== '0 || obs_pre !== exp_pre) begin
        n_fail++;
        $display("FAIL idle_drop.pix%0d got we=%b col=%0d want we=0 col=0", i, obs_pre[0], col);
      end
    end
    step(1, 1, 1, 0);
    n_checks++;
    if (obs_pre[0] !== 1'b1 || col !== CW'(1) || obs_post !== exp_post) begin
      n_fail++;
      $display("FAIL idle_drop.sof got we=%b col=%0d post=%b want we=1 col=1 post=%b",
               obs_pre[0], col, obs_post, exp_post);
    end
  endtask

  task automatic test_full_frame();
    int we_cnt = 0, eol_cnt = 0, eof_cnt = 0, fd_cnt = 0;
    step(0, 0, 1, 1);
    consumed = 0;
    for (int p = 0; p < NPIX + 2; p++) begin
      step(p < NPIX, p == 0, 1, 0);
      if (obs_pre[0] === 1'b1) we_cnt++;
      if (win_eol === 1'b1) eol_cnt++;
      if (win_eof === 1'b1) eof_cnt++;
      if (frame_done === 1'b1) fd_cnt++;
      n_checks++;
      if (obs_pre !== exp_pre || obs_post !== exp_post) begin
        n_fail++;
        $display("FAIL full_frame.p%0d got %b/%b want %b/%b", p, obs_pre, obs_post, exp_pre, exp_post);
      end
    end
    n_checks++;
    if (we_cnt != NPIX || consumed != NWIN || eol_cnt != H - K + 1 || eof_cnt != 1 || fd_cnt != 1) begin
      n_fail++;
      $display("FAIL full_frame.counts got we=%0d win=%0d eol=%0d eof=%0d fd=%0d want %0d %0d %0d 1 1",
               we_cnt, consumed, eol_cnt, eof_cnt, fd_cnt, NPIX, NWIN, H - K + 1);
    end
  endtask

  task automatic test_midframe_sof();
    int wv_cnt = 0;
    step(0, 0, 1, 1);
    for (int p = 0; p < W + 2; p++) step(1, p == 0, 1, 0);
    step(1, 1, 1, 0);
    n_checks++;
    if (sof_error !== 1'b1 || col !== CW'(1) || row !== '0 || obs_post !== exp_post) begin
      n_fail++;
      $display("FAIL midframe_sof.restart got serr=%b col=%0d row=%0d want serr=1 col=1 row=0",
               sof_error, col, row);
    end
    step(1, 0, 1, 0);
    n_checks++;
    if (sof_error !== 1'b0) begin n_fail++; $display("FAIL midframe_sof.pulse got %b want 0", sof_error); end
    for (int p = 2; p < NPIX; p++) begin
      step(1, 0, 1, 0);
      if (win_valid === 1'b1) wv_cnt++;
      n_checks++;
      if (obs_pre !== exp_pre || obs_post !== exp_post || (p < (K - 1) * W && win_valid !== 1'b0)) begin
        n_fail++;
        $display("FAIL midframe_sof.p%0d got %b/%b want %b/%b", p, obs_pre, obs_post, exp_pre, exp_post);
      end
    end
    n_checks++;
    if (wv_cnt != NWIN) begin n_fail++; $display("FAIL midframe_sof.windows got %0d want %0d", wv_cnt, NWIN); end
  endtask

  task automatic test_backpressure();
    logic [CW-1:0] hc;
    logic [RW-1:0] hr;
    step(0, 0, 1, 1);
    consumed = 0;
    for (int p = 0; p < 2 * W + 4; p++) step(1, p == 0, 1, 0);
    hc = col; hr = row;
    n_checks++;
    if (win_valid !== 1'b1) begin n_fail++; $display("FAIL backpressure.pre got wv=%b want 1", win_valid); end
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0);
      n_checks++;
      if (obs_pre !== 2'b00 || win_valid !== 1'b1 || col !== hc || row !== hr || obs_post !== exp_post) begin
        n_fail++;
        $display("FAIL backpressure.stall%0d got rdy/we=%b wv=%b col=%0d row=%0d want 00 1 %0d %0d",
                 i, obs_pre, win_valid, col, row, hc, hr);
      end
    end
    for (int p = 2 * W + 4; p < NPIX + 1; p++) begin
      step(p < NPIX, 0, 1, 0);
      n_checks++;
      if (obs_pre !== exp_pre || obs_post !== exp_post) begin
        n_fail++;
        $display("FAIL backpressure.p%0d got %b/%b want %b/%b", p, obs_pre, obs_post, exp_pre, exp_post);
      end
    end
    n_checks++;
    if (consumed != NWIN) begin n_fail++; $display("FAIL backpressure.windows got %0d want %0d", consumed, NWIN); end
  endtask

  task automatic test_reset_midframe();
    step(0, 0, 1, 1);
    for (int p = 0; p < W + 1; p++) step(1, p == 0, 1, 0);
    step(1, 0, 1, 1);
    n_checks++;
    if (obs_post !== '0) begin n_fail++; $display("FAIL reset_midframe.outputs got %b want 0", obs_post); end
    step(1, 0, 1, 0);
    n_checks++;
    if (obs_pre !== 2'b10 || obs_post !== '0) begin
      n_fail++;
      $display("FAIL reset_midframe.drop got rdy/we=%b post=%b want 10 0", obs_pre, obs_post);
    end
  endtask

  task automatic test_back_to_back();
    int wv_cnt, fd_cnt, p;
    step(0, 0, 1, 1);
    for (int f = 0; f < 2; f++) begin
      wv_cnt = 0; fd_cnt = 0; p = 0;
      for (int c = 0; c < 4 * NPIX && p < NPIX; c++) begin
        step(1, p == 0, 1, 0);
        if (exp_pre[0]) p++;
        if (win_valid === 1'b1) wv_cnt++;
        if (frame_done === 1'b1) fd_cnt++;
        n_checks++;
        if (obs_pre !== exp_pre || obs_post !== exp_post) begin
          n_fail++;
          $display("FAIL back_to_back.f%0d.p%0d got %b/%b want %b/%b", f, p, obs_pre, obs_post, exp_pre, exp_post);
        end
      end
      n_checks++;
      if (p != NPIX || wv_cnt != NWIN || fd_cnt != 1) begin
        n_fail++;
        $display("FAIL back_to_back.f%0d.counts got pix=%0d win=%0d fd=%0d want %0d %0d 1", f, p, wv_cnt, fd_cnt, NPIX, NWIN);
      end
    end
  endtask

  task automatic test_random();
    step(0, 0, 1, 1);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0,
           $urandom_range(0, 5) != 0, $urandom_range(0, 499) == 0);
      n_checks++;
      if (obs_pre !== exp_pre || obs_post !== exp_post) begin
        n_fail++;
        $display("FAIL random.c%0d got %b/%b want %b/%b", i, obs_pre, obs_post, exp_pre, exp_post);
      end
    end
  endtask

  initial begin
    reset = 1'b1; s_valid = 1'b0; s_sof = 1'b0; m_ready = 1'b1;
    consumed = 0;
    model_update(0, 0, 1, 1);
    test_reset();
    test_idle_drop();
    test_full_frame();
    test_midframe_sof();
    test_backpressure();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/line_buffer_ctrl.md
Name: line_buffer_ctrl

Overview:
- Sequences the 1280-deep line buffers and the 3x3 window registers of the pattern recognizer.
- Accepts a raster pixel stream with a start-of-frame marker and tracks column and row.
- Drives the line-buffer write enable and flags when the window is fully populated with valid pixels.
- Propagates downstream back-pressure to the pixel source; sits between the pixel source and the line buffers/recognizer core.

Parameters:
IMG_WIDTH, 1280, pixels per line; must equal line-buffer depth.
IMG_HEIGHT, 720, lines per frame.
KERNEL, 3, window size; first valid window at row>=KERNEL-1 and col>=KERNEL-1.
COL_W, 11, column counter width, ceil(log2(IMG_WIDTH)).
ROW_W, 10, row counter width, ceil(log2(IMG_HEIGHT)).

Ports:
clk  in  1  single clock, rising edge.
reset  in  1  synchronous, active-high.
s_valid  in  1  source pixel valid.
s_sof  in  1  qualifies the current s_valid pixel as frame pixel (0,0).
s_ready  out  1  controller can accept a pixel.
m_ready  in  1  downstream core can take a window.
lb_write_enable  out  1  combinational; equals accept; drives the line-buffer write_enable in the same cycle the pixel is presented.
col  out  COL_W  column of the next expected pixel.
row  out  ROW_W  row of the next expected pixel.
win_valid  out  1  registered; the window is complete and aligned with the line-buffer outputs.
win_eol  out  1  with win_valid; last window of a row (pixel col = IMG_WIDTH-1).
win_eof  out  1  with win_valid; last window of the frame.
frame_done  out  1  one-cycle pulse after the last frame pixel is accepted.
sof_error  out  1  one-cycle pulse when s_sof arrives mid-frame.

Behaviour:
- Reset (synchronous, active-high; sampled on clk rising edge):
  - state=IDLE; col=0, row=0.
  - win_valid, win_eol, win_eof, frame_done, sof_error = 0.
  - Reset overrides every other event, including mid-frame operation.
- Handshake:
  - s_ready = m_ready when state is IDLE or ACTIVE; s_ready = 0 in DONE.
  - accept = s_valid & s_ready.
- State IDLE:
  - accept with s_sof=1: the pixel is (0,0), lb_write_enable=1, col becomes 1, go to ACTIVE.
  - accept with s_sof=0: pixel dropped, lb_write_enable=0, counters unchanged.
- State ACTIVE, per accept:
  - lb_write_enable=1.
  - col increments; at IMG_WIDTH-1 it wraps to 0 and row increments.
  - On accepting pixel (IMG_WIDTH-1, IMG_HEIGHT-1): col=0, row=0, go to DONE.
- State DONE:
  - Lasts exactly one cycle with frame_done=1, then returns to IDLE.
  - s_ready=0 during this cycle.
- Mid-frame s_sof (ACTIVE, accept with s_sof=1):
  - The frame restarts: the pixel is (0,0), col=1, row=0.
  - sof_error=1 for one cycle.
  - Window qualification restarts from row 0.
- Window timing:
  - win_valid is set 1 cycle after accepting an ACTIVE-frame pixel with pixel row>=KERNEL-1 and pixel col>=KERNEL-1.
  - This aligns with the registered line-buffer data_out.
  - win_eol and win_eof are registered alongside win_valid from the same accepted pixel's position.
  - win_valid clears when m_ready=1 and no new qualifying accept occurs in that cycle.
  - While m_ready=0, win_valid/eol/eof hold their values; s_ready=0, so no pixel is lost.
- Counters are modulo IMG_WIDTH/IMG_HEIGHT; no count ever exceeds IMG_WIDTH-1 or IMG_HEIGHT-1.
- A pixel with s_valid=0 never changes state or counters.

Test Plan:
- IMG_WIDTH=4, IMG_HEIGHT=3, KERNEL=3, m_ready=1: sof plus 12 consecutive pixels.
  - lb_write_enable high 12 cycles.
  - win_valid high for pixels (2,2),(2,3), each 1 cycle after the accept; win_eol on (2,3); win_eof on (2,3).
  - frame_done pulse follows; state returns to IDLE.
- 5 pixels with s_sof=0 while IDLE, then a sof pixel.
  - lb_write_enable=0 for the first 5; col=0 until the sof pixel, then col=1.
- Mid-frame sof at pixel (1,2):
  - sof_error pulses; col=1, row=0.
  - No win_valid until row 2 of the restarted frame.
- m_ready=0 for 3 cycles while win_valid=1:
  - s_ready=0, win_valid held, counters frozen, lb_write_enable=0.
  - On m_ready=1 the stream resumes with no dropped or duplicated windows.
- Assert reset at pixel (1,1) with s_valid=1:
  - Next cycle col=0, row=0, IDLE, all outputs 0.
  - A non-sof pixel is then dropped.
- Default parameters, two back-to-back frames:
  - Frame 1 yields 718*1278 win_valid cycles, one frame_done, col wraps at 1279.
  - Frame 2 yields identical counts.
